// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding and
// default timing constants.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
  localparam int DEFAULT_GAP_CYCLES     = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest set req bit at or above
// (last_owner+1) mod NUM_REQ, wrapping around.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants one transaction engine at a time ownership of the shared I2C pins,
// with round-robin fairness, an enforced idle gap and a stuck-owner watchdog.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] scl_oe_in,
  input  logic [NUM_REQ-1:0] sda_oe_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               scl_oe,
  output logic               sda_oe,
  output logic               timeout
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] last_owner;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_release;
  logic             wd_expired;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  // grant is one-hot, so masking with it selects only the owner's done/req.
  assign owner_release = |(grant & (done | ~req));
  assign wd_expired    = (wd_cnt == WD_LAST);

  assign scl_oe = |(scl_oe_in & grant);
  assign sda_oe = |(sda_oe_in & grant);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      busy       <= 1'b0;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant  <= NUM_REQ'(1) << pick_idx;
            owner  <= pick_idx;
            wd_cnt <= '0;
            busy   <= 1'b1;
            state  <= OWN;
          end
        end
        OWN: begin
          if (owner_release || wd_expired) begin
            grant      <= '0;
            last_owner <= owner;
            gap_cnt    <= GAP_LOAD;
            // A normal release on the expiry cycle wins over the watchdog.
            timeout    <= !owner_release;
            state      <= GAP;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares one open-drain I2C bus (scl/sda) between several transaction engines, such as the configuration writer and the periodic register poller, that would otherwise drive the same pins. It grants exclusive bus ownership to one requester at a time using a req/grant/done handshake with round-robin fairness. It forces a bus-free gap between owners and reclaims the bus from a stuck owner via a watchdog. It sits between the engines' pull-low enables and the top-level pad tristate logic.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYCLES, 65535: maximum grant duration in clock cycles before forced release (≥ 1).
- GAP_CYCLES, 4: idle cycles with no owner between grants (≥ 1).
- clock  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request, level; held until done or withdrawn.
- done  in  NUM_REQ  per-requester end-of-transaction pulse (1 cycle).
- scl_oe_in  in  NUM_REQ  per-requester "pull scl low" enable.
- sda_oe_in  in  NUM_REQ  per-requester "pull sda low" enable.
- grant  out  NUM_REQ  one-hot (or zero) ownership, registered.
- owner  out  max(1,clog2(NUM_REQ))  index of current or last owner, registered.
- busy  out  1  high while any grant is active or during the gap.
- scl_oe  out  1  pad pull-low enable for scl.
- sda_oe  out  1  pad pull-low enable for sda.
- timeout  out  1  one-cycle pulse on watchdog release.

## Operation
- State machine: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is set, select a winner by round robin, searching from index (last_owner+1) mod NUM_REQ upward with wrap-around.
  - Set grant[winner], load owner, clear the watchdog counter, go to OWN.
  - After reset, last_owner = NUM_REQ-1, so index 0 wins first.
- OWN, release conditions:
  - done[owner]=1, or req[owner]=0: release.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no release: release and pulse timeout.
  - On release: clear grant, record last_owner = owner, load the gap counter, go to GAP.
  - If done and deassertion coincide, this is one release. If timeout coincides with done, it counts as a normal release and timeout stays 0.
- OWN, ignored inputs: done and req changes from non-owners. Requests from others simply wait.
- GAP:
  - Count GAP_CYCLES cycles with grant=0, then go to IDLE.
  - Requests asserted during the gap are arbitrated in IDLE on the cycle after the gap.
- Pad enables: scl_oe = OR over i of (scl_oe_in[i] & grant[i]); sda_oe the same. Combinational from the registered grant. Non-owner enables never reach the pads, and both enables are 0 in IDLE and GAP.
- owner holds its last value in IDLE and GAP.
- Counter widths: clog2(TIMEOUT_CYCLES+1) and clog2(GAP_CYCLES+1). No wrap: the counters saturate and are reloaded on state entry.

## Timing
- Reset (asynchronous, immediate):
  - grant=0, owner=0, busy=0, timeout=0, scl_oe=0, sda_oe=0, state=IDLE.
  - last_owner=NUM_REQ-1.
  - Mid-transaction reset drops the bus immediately; the engines must handle a lost transaction.
- Grant latency: req rising in IDLE gives grant at the next clock edge, i.e. 1 cycle.
- Release latency: done[owner] at edge k gives grant=0 after edge k+1. scl_oe/sda_oe go to 0 in the same cycle.
- Watchdog: the counter starts at 0 on the grant edge, so grant is high for exactly TIMEOUT_CYCLES cycles when never released. timeout is high for the first cycle of GAP.
- Minimum spacing between two grants: GAP_CYCLES+1 cycles of grant=0 (GAP plus one IDLE evaluation cycle).
- busy = (state != IDLE), registered.

## Structure
- Shared package i2c_arb_pkg holds:
  - the state encoding (IDLE=2'd0, OWN=2'd1, GAP=2'd2);
  - the default constants for timeout and gap.
- Sub-module rr_picker (combinational): inputs req vector and last_owner; outputs valid and winner index. Reusable by other shared-resource controllers in the design.
- Top-level integration:
  - ties the setup engine to index 0 and the poller to index 1;
  - pads drive 0 when *_oe=1, and are high-Z otherwise.

## Test plan
- Reset then req=2'b11 held: grant=01 after 1 cycle. done[0] gives grant=00 for GAP_CYCLES+1 cycles, then grant=10 (round robin).
- req[1] alone with scl_oe_in=2'b11, sda_oe_in=2'b01: scl_oe=1, sda_oe=0 while owner=1. scl_oe=0 in GAP.
- Requester 0 granted and never done, TIMEOUT_CYCLES=16: grant high for exactly 16 cycles, then a 1-cycle timeout pulse, then GAP.
- done[1] pulsed while owner=0: no release. req[0] dropped: release on the next edge, with no timeout pulse.
- reset_n low for 1 ns mid-grant, between clock edges: grant, scl_oe and sda_oe go to 0 asynchronously. After release, req=2'b11 grants index 0 first.
- NUM_REQ=3, all requesting continuously, each done after 5 cycles: grant order 0,1,2,0,1,2, with no starvation over 30 grants.
